// File: rtl/bambu_slave_pkg.sv
// Shared types and defaults for the Bambu slave-port initiator.
package bambu_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int unsigned DEF_ADDR_W = 7;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_SIZE_W = 4;
    localparam int unsigned MAX_DATA_W = 64;

    // Low 'size' bits set; callers truncate to their own data width.
    function automatic logic [MAX_DATA_W-1:0] size_mask(input int unsigned size);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            m[i] = (i < size);
        end
        return m;
    endfunction

endpackage

// File: rtl/bambu_slave_lane_mux.sv
// Steers the registered request onto one channel slice of the packed S_* buses
// and selects that channel's read-data slice.
module bambu_slave_lane_mux
    import bambu_slave_pkg::*;
#(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SIZE_W = DEF_SIZE_W,
    parameter int unsigned CH_W   = 1
) (
    input  logic                     active_i,
    input  logic                     we_i,
    input  logic [CH_W-1:0]          ch_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [SIZE_W-1:0]        size_i,
    input  logic [N_CH*DATA_W-1:0]   rdata_bus_i,
    output logic [N_CH-1:0]          oe_o,
    output logic [N_CH-1:0]          we_o,
    output logic [N_CH*ADDR_W-1:0]   addr_o,
    output logic [N_CH*DATA_W-1:0]   wdata_o,
    output logic [N_CH*SIZE_W-1:0]   size_o,
    output logic [DATA_W-1:0]        rdata_o
);

    always_comb begin
        oe_o    = '0;
        we_o    = '0;
        addr_o  = '0;
        wdata_o = '0;
        size_o  = '0;
        rdata_o = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (ch_i == CH_W'(c)) begin
                rdata_o = rdata_bus_i[c*DATA_W +: DATA_W];
                if (active_i) begin
                    oe_o[c]                      = !we_i;
                    we_o[c]                      = we_i;
                    addr_o[c*ADDR_W +: ADDR_W]   = addr_i;
                    wdata_o[c*DATA_W +: DATA_W]  = wdata_i;
                    size_o[c*SIZE_W +: SIZE_W]   = size_i;
                end
            end
        end
    end

endmodule

// File: rtl/bambu_slave_port_initiator.sv
// Single-outstanding command initiator for the S_* slave memory port of an HLS core.
// Optional protocol checker: define SLAVE_PROTO_CHECK_EN.
module bambu_slave_port_initiator
    import bambu_slave_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned SIZE_W  = DEF_SIZE_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [$clog2(N_CH)-1:0]   cmd_ch,
    input  logic                      cmd_we,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [SIZE_W-1:0]         cmd_size,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [N_CH-1:0]           S_oe_ram,
    output logic [N_CH-1:0]           S_we_ram,
    output logic [N_CH*ADDR_W-1:0]    S_addr_ram,
    output logic [N_CH*DATA_W-1:0]    S_Wdata_ram,
    output logic [N_CH*SIZE_W-1:0]    S_data_ram_size,
    input  logic [N_CH*DATA_W-1:0]    Sout_Rdata_ram,
    input  logic [N_CH-1:0]           Sout_DataRdy,
    output logic                      proto_err
);

    localparam int unsigned CH_W  = $clog2(N_CH);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   lane_rdata;
    logic                size_bad;

    assign size_bad = (cmd_size == '0) || (32'(cmd_size) > DATA_W);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        timer_d = timer_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ch_d    = cmd_ch;
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    size_d  = cmd_size;
                    wdata_d = cmd_wdata & DATA_W'(size_mask(32'(cmd_size)));
                    timer_d = '0;
                    rdata_d = '0;
                    err_d   = size_bad;
                    state_d = size_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                timer_d = timer_q + 1'b1;
                // Completion wins over timeout when both land in the same cycle.
                if (Sout_DataRdy[ch_q]) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : lane_rdata;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            timer_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    bambu_slave_lane_mux #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W),
        .CH_W   (CH_W)
    ) u_lane (
        .active_i    (state_q == ISSUE),
        .we_i        (we_q),
        .ch_i        (ch_q),
        .addr_i      (addr_q),
        .wdata_i     (wdata_q),
        .size_i      (size_q),
        .rdata_bus_i (Sout_Rdata_ram),
        .oe_o        (S_oe_ram),
        .we_o        (S_we_ram),
        .addr_o      (S_addr_ram),
        .wdata_o     (S_Wdata_ram),
        .size_o      (S_data_ram_size),
        .rdata_o     (lane_rdata)
    );

`ifdef SLAVE_PROTO_CHECK_EN
    logic [N_CH-1:0] active_mask;
    logic [N_CH-1:0] rdy_prev_q;
    logic            proto_err_q;
    logic            stray_rdy, double_rdy, orphan_ready;

    always_comb begin
        active_mask = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if ((state_q == ISSUE) && (ch_q == CH_W'(c))) begin
                active_mask[c] = 1'b1;
            end
        end
    end

    assign stray_rdy    = |(Sout_DataRdy & ~active_mask);
    assign double_rdy   = |(Sout_DataRdy & rdy_prev_q & active_mask);
    assign orphan_ready = rsp_ready && !rsp_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            proto_err_q <= 1'b0;
            rdy_prev_q  <= '0;
        end else begin
            rdy_prev_q <= Sout_DataRdy;
            if (stray_rdy || double_rdy || orphan_ready) begin
                proto_err_q <= 1'b1;
            end
            if (stray_rdy)    $display("bambu_slave_port_initiator: DataRdy on inactive channel %b", Sout_DataRdy);
            if (double_rdy)   $display("bambu_slave_port_initiator: DataRdy held two cycles");
            if (orphan_ready) $display("bambu_slave_port_initiator: rsp_ready without rsp_valid");
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_bambu_slave_port_initiator.sv
// Directed, table-driven bench for bambu_slave_port_initiator (2 channels, 7/8/4 widths, TIMEOUT 255).
module tb_bambu_slave_port_initiator;

    localparam int unsigned N_CH    = 2;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SIZE_W  = 4;
    localparam int unsigned TIMEOUT = 255;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_ch;
    logic                     cmd_we;
    logic [ADDR_W-1:0]        cmd_addr;
    logic [DATA_W-1:0]        cmd_wdata;
    logic [SIZE_W-1:0]        cmd_size;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic [N_CH-1:0]          S_oe_ram;
    logic [N_CH-1:0]          S_we_ram;
    logic [N_CH*ADDR_W-1:0]   S_addr_ram;
    logic [N_CH*DATA_W-1:0]   S_Wdata_ram;
    logic [N_CH*SIZE_W-1:0]   S_data_ram_size;
    logic [N_CH*DATA_W-1:0]   Sout_Rdata_ram;
    logic [N_CH-1:0]          Sout_DataRdy;
    logic                     proto_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    bambu_slave_port_initiator #(
        .N_CH    (N_CH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SIZE_W  (SIZE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_ch          (cmd_ch),
        .cmd_we          (cmd_we),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_size        (cmd_size),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy),
        .proto_err       (proto_err)
    );

    typedef struct {
        logic              we;
        logic              ch;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SIZE_W-1:0] size;
        int                rdy_at;      // ISSUE cycle carrying DataRdy, 0 = never
        logic [DATA_W-1:0] core_rdata;
        logic              stray;       // pulse DataRdy on the other channel in ISSUE cycle 1
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
        logic [DATA_W-1:0] exp_wslice;
        int                exp_cycles;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic ch, input logic [6:0] addr,
                                input logic [7:0] wdata, input logic [3:0] size, input int rdy_at,
                                input logic [7:0] core, input logic stray, input logic err,
                                input logic [7:0] rdata, input logic [7:0] wslice, input int cycles);
        vec_t v;
        v.we = we; v.ch = ch; v.addr = addr; v.wdata = wdata; v.size = size;
        v.rdy_at = rdy_at; v.core_rdata = core; v.stray = stray; v.exp_err = err;
        v.exp_rdata = rdata; v.exp_wslice = wslice; v.exp_cycles = cycles;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_vec(input vec_t v, input string tag);
        logic [1:0]  e_oe, e_we;
        logic [13:0] e_addr;
        logic [15:0] e_wd;
        logic [7:0]  e_sz;
        logic        held_ok;
        int          cyc;
        e_oe   = v.we ? 2'b00 : (2'b01 << v.ch);
        e_we   = v.we ? (2'b01 << v.ch) : 2'b00;
        e_addr = 14'(v.addr) << (7 * int'(v.ch));
        e_wd   = 16'(v.exp_wslice) << (8 * int'(v.ch));
        e_sz   = 8'(v.size) << (4 * int'(v.ch));
        held_ok = 1'b1;

        cmd_valid = 1'b1; cmd_ch = v.ch; cmd_we = v.we; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_size = v.size;
        @(negedge clock);
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;

        for (cyc = 0; cyc < 300; cyc++) begin
            if (v.stray && cyc == 0) begin
                Sout_DataRdy[!v.ch] = 1'b1;
                Sout_Rdata_ram[8*int'(!v.ch) +: 8] = 8'hEE;
            end
            if (v.rdy_at != 0 && cyc + 1 == v.rdy_at) begin
                Sout_DataRdy[v.ch] = 1'b1;
                Sout_Rdata_ram[8*int'(v.ch) +: 8]  = v.core_rdata;
                Sout_Rdata_ram[8*int'(!v.ch) +: 8] = ~v.core_rdata;
            end
            @(negedge clock);
            if (rsp_valid) break;
            if (cyc == 0) begin
                chk({tag, ".S_oe"},    64'(S_oe_ram),        64'(e_oe));
                chk({tag, ".S_we"},    64'(S_we_ram),        64'(e_we));
                chk({tag, ".S_addr"},  64'(S_addr_ram),      64'(e_addr));
                chk({tag, ".S_Wdata"}, 64'(S_Wdata_ram),     64'(e_wd));
                chk({tag, ".S_size"},  64'(S_data_ram_size), 64'(e_sz));
            end
            if ({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size} !== {e_oe, e_we, e_addr, e_wd, e_sz})
                held_ok = 1'b0;
            tick();
            Sout_DataRdy   = '0;
            Sout_Rdata_ram = '0;
        end
        Sout_DataRdy   = '0;
        Sout_Rdata_ram = '0;

        chk({tag, ".issue_cycles"}, 64'(cyc), 64'(v.exp_cycles));
        if (v.exp_cycles > 0) chk({tag, ".S_held"}, 64'(held_ok), 64'd1);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".rsp_err"},   64'(rsp_err),   64'(v.exp_err));
        chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        chk({tag, ".S_idle_in_resp"},
            64'({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size}), 64'd0);
        chk({tag, ".cmd_ready_in_resp"}, 64'(cmd_ready), 64'd0);

        tick();
        @(negedge clock);
        chk({tag, ".rsp_hold_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".rsp_hold_data"},  64'({rsp_err, rsp_rdata}), 64'({v.exp_err, v.exp_rdata}));
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        @(negedge clock);
        chk({tag, ".after_ack"}, 64'({cmd_ready, rsp_valid}), 64'b10);
        tick();
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(1, 0, 7'h05, 8'hA5, 4'd8,   2, 8'hDE, 0, 0, 8'h00, 8'hA5,   2);
        vecs[1] = mk(0, 1, 7'h10, 8'h00, 4'd8,   3, 8'h3C, 1, 0, 8'h3C, 8'h00,   3);
        vecs[2] = mk(1, 1, 7'h7F, 8'hFF, 4'd4,   1, 8'h00, 0, 0, 8'h00, 8'h0F,   1);
        vecs[3] = mk(1, 0, 7'h01, 8'hFE, 4'd3,   1, 8'h00, 0, 0, 8'h00, 8'h06,   1);
        vecs[4] = mk(0, 0, 7'h00, 8'h00, 4'd1,   1, 8'h81, 0, 0, 8'h81, 8'h00,   1);
        vecs[5] = mk(1, 0, 7'h11, 8'h55, 4'd0,   0, 8'h00, 0, 1, 8'h00, 8'h00,   0);
        vecs[6] = mk(0, 1, 7'h12, 8'h00, 4'd9,   0, 8'h00, 0, 1, 8'h00, 8'h00,   0);
        vecs[7] = mk(1, 0, 7'h2A, 8'h3C, 4'd15,  0, 8'h00, 0, 1, 8'h00, 8'h00,   0);
        vecs[8] = mk(0, 0, 7'h20, 8'h00, 4'd8,   0, 8'h99, 0, 1, 8'h00, 8'h00, 255);
        vecs[9] = mk(0, 1, 7'h21, 8'h00, 4'd8, 255, 8'h5A, 0, 0, 8'h5A, 8'h00, 255);

        reset = 1'b1; cmd_valid = 1'b0; cmd_ch = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_size = '0; rsp_ready = 1'b0; Sout_Rdata_ram = '0; Sout_DataRdy = '0;
        tick();
        tick();
        @(negedge clock);
        chk("reset.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("reset.rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
        chk("reset.S_bus", 64'({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size}), 64'd0);
        chk("reset.proto_err", 64'(proto_err), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset.cmd_ready", 64'(cmd_ready), 64'd1);
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

`ifndef SLAVE_PROTO_CHECK_EN
        chk("proto_err_tied_low", 64'(proto_err), 64'd0);
`endif

        // Reset lands in the second ISSUE cycle of a read that never completes.
        cmd_valid = 1'b1; cmd_ch = 1'b0; cmd_we = 1'b0; cmd_addr = 7'h22; cmd_wdata = '0; cmd_size = 4'd8;
        tick();
        cmd_valid = 1'b0;
        @(negedge clock);
        chk("abort.issue1_oe", 64'(S_oe_ram), 64'b01);
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("abort.issue2_oe_still", 64'(S_oe_ram), 64'b01);
        tick();
        @(negedge clock);
        chk("abort.S_bus", 64'({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size}), 64'd0);
        chk("abort.rsp", 64'({cmd_ready, rsp_valid, rsp_err, rsp_rdata, proto_err}), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("abort.idle_no_rsp", 64'({cmd_ready, rsp_valid}), 64'b10);
        tick();
        run_vec(mk(0, 1, 7'h33, 8'h00, 4'd8, 1, 8'hC3, 0, 0, 8'hC3, 8'h00, 1), "fresh");

`ifdef SLAVE_PROTO_CHECK_EN
        chk("proto.clean_before", 64'(proto_err), 64'd0);
        Sout_DataRdy = 2'b10;
        tick();
        Sout_DataRdy = 2'b00;
        @(negedge clock);
        chk("proto.set", 64'(proto_err), 64'd1);
        tick();
        tick();
        @(negedge clock);
        chk("proto.sticky", 64'(proto_err), 64'd1);
        chk("proto.no_rsp", 64'(rsp_valid), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
